// File: rtl/param_rs_pkg.sv
// Shared constants for the parametrised ALU reservation station.
// Default geometry plus the reserved "operand ready" tag value.
package param_rs_pkg;

   localparam bit TRUE  = 1'b1;
   localparam bit FALSE = 1'b0;

   localparam int RS_DEPTH_DEF = 16;
   localparam int RS_W_DEF     = 4;
   localparam int ROB_W_DEF    = 4;
   localparam int OP_W_DEF     = 6;
   localparam int DATA_W_DEF   = 32;
   localparam int N_CDB_DEF    = 2;

   // ROB tag 0 never names a producer; it means the value is present.
   localparam int TAG_READY = 0;

endpackage

// File: rtl/param_rs_pick.sv
// Lowest-index priority encoder used for free-slot and ready-entry
// selection inside the reservation station.
module param_rs_pick
   import param_rs_pkg::*;
#(
   parameter int N = RS_DEPTH_DEF,
   parameter int W = RS_W_DEF
) (
   input  logic [N-1:0] req_in,
   output logic         found_out,
   output logic [W-1:0] idx_out
);

   // Scan high to low so the lowest set request is the last one written
   always_comb begin
      found_out = FALSE;
      idx_out   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_in[i]) begin
            found_out = TRUE;
            idx_out   = W'(i);
         end
      end
   end

endmodule

// File: rtl/param_rs.sv
// Tomasulo reservation station for one ALU: holds dispatched ops,
// snoops CDB channels for wake-up, issues one ready op per cycle.
module param_rs
   import param_rs_pkg::*;
#(
   parameter int RS_DEPTH = RS_DEPTH_DEF,
   parameter int RS_W     = RS_W_DEF,
   parameter int ROB_W    = ROB_W_DEF,
   parameter int OP_W     = OP_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int N_CDB    = N_CDB_DEF
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    rdy_in,
   input  logic                    clear_in,
   input  logic                    dp_valid_in,
   input  logic [OP_W-1:0]         dp_op_in,
   input  logic [ROB_W-1:0]        dp_qj_in,
   input  logic [ROB_W-1:0]        dp_qk_in,
   input  logic [DATA_W-1:0]       dp_vj_in,
   input  logic [DATA_W-1:0]       dp_vk_in,
   input  logic [DATA_W-1:0]       dp_imm_in,
   input  logic [ROB_W-1:0]        dp_rob_id_in,
   output logic                    full_out,
   input  logic                    alu_idle_in,
   output logic                    alu_valid_out,
   output logic [OP_W-1:0]         alu_op_out,
   output logic [DATA_W-1:0]       alu_vj_out,
   output logic [DATA_W-1:0]       alu_vk_out,
   output logic [DATA_W-1:0]       alu_imm_out,
   output logic [ROB_W-1:0]        alu_rob_id_out,
   input  logic [N_CDB-1:0]        cdb_valid_in,
   input  logic [N_CDB*ROB_W-1:0]  cdb_rob_id_in,
   input  logic [N_CDB*DATA_W-1:0] cdb_value_in
);

   localparam logic [ROB_W-1:0] TAG0 = ROB_W'(TAG_READY);
   localparam logic [RS_W:0]    FULL_AT = (RS_W+1)'(RS_DEPTH - 1);
   localparam logic [RS_W:0]    MAX_CNT = (RS_W+1)'(RS_DEPTH);

   logic [RS_DEPTH-1:0] busy_q;
   logic [OP_W-1:0]     op_q  [RS_DEPTH];
   logic [ROB_W-1:0]    qj_q  [RS_DEPTH];
   logic [ROB_W-1:0]    qk_q  [RS_DEPTH];
   logic [DATA_W-1:0]   vj_q  [RS_DEPTH];
   logic [DATA_W-1:0]   vk_q  [RS_DEPTH];
   logic [DATA_W-1:0]   imm_q [RS_DEPTH];
   logic [ROB_W-1:0]    rob_q [RS_DEPTH];
   logic [RS_W:0]       count_q;

   logic [ROB_W-1:0]    cdb_tag [N_CDB];
   logic [DATA_W-1:0]   cdb_val [N_CDB];

   logic [RS_DEPTH-1:0] jhit;
   logic [RS_DEPTH-1:0] khit;
   logic [DATA_W-1:0]   jval [RS_DEPTH];
   logic [DATA_W-1:0]   kval [RS_DEPTH];
   logic                dj_hit;
   logic                dk_hit;
   logic [DATA_W-1:0]   dj_val;
   logic [DATA_W-1:0]   dk_val;

   logic [RS_DEPTH-1:0] free_req;
   logic [RS_DEPTH-1:0] rdy_req;
   logic                free_found;
   logic                rdy_found;
   logic [RS_W-1:0]     free_idx;
   logic [RS_W-1:0]     rdy_idx;
   logic                dp_acc;
   logic                iss;

   // Unpack the broadcast buses into per-channel tag/value
   always_comb begin
      for (int c = 0; c < N_CDB; c++) begin
         cdb_tag[c] = cdb_rob_id_in[c*ROB_W +: ROB_W];
         cdb_val[c] = cdb_value_in[c*DATA_W +: DATA_W];
      end
   end

   // Tag match for stored entries and the incoming dispatch; low channel wins
   always_comb begin
      jhit   = '0;
      khit   = '0;
      dj_hit = FALSE;
      dk_hit = FALSE;
      dj_val = '0;
      dk_val = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         jval[i] = '0;
         kval[i] = '0;
      end
      for (int c = N_CDB - 1; c >= 0; c--) begin
         if (cdb_valid_in[c] && cdb_tag[c] != TAG0) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
               if (qj_q[i] == cdb_tag[c]) begin
                  jhit[i] = TRUE;
                  jval[i] = cdb_val[c];
               end
               if (qk_q[i] == cdb_tag[c]) begin
                  khit[i] = TRUE;
                  kval[i] = cdb_val[c];
               end
            end
            if (dp_qj_in == cdb_tag[c]) begin
               dj_hit = TRUE;
               dj_val = cdb_val[c];
            end
            if (dp_qk_in == cdb_tag[c]) begin
               dk_hit = TRUE;
               dk_val = cdb_val[c];
            end
         end
      end
   end

   // Request vectors for the two priority encoders
   always_comb begin
      free_req = ~busy_q;
      for (int i = 0; i < RS_DEPTH; i++) begin
         rdy_req[i] = busy_q[i] && qj_q[i] == TAG0 && qk_q[i] == TAG0;
      end
   end

   param_rs_pick #(.N(RS_DEPTH), .W(RS_W)) u_free (
      .req_in    (free_req),
      .found_out (free_found),
      .idx_out   (free_idx)
   );

   param_rs_pick #(.N(RS_DEPTH), .W(RS_W)) u_ready (
      .req_in    (rdy_req),
      .found_out (rdy_found),
      .idx_out   (rdy_idx)
   );

   assign dp_acc   = dp_valid_in && free_found;
   assign iss      = alu_idle_in && rdy_found;
   assign full_out = count_q >= FULL_AT;

   // Entry state, wake-up, issue register and occupancy count
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         busy_q         <= '0;
         count_q        <= '0;
         alu_valid_out  <= FALSE;
         alu_op_out     <= '0;
         alu_vj_out     <= '0;
         alu_vk_out     <= '0;
         alu_imm_out    <= '0;
         alu_rob_id_out <= '0;
      end else if (rdy_in) begin
         if (clear_in) begin
            busy_q        <= '0;
            count_q       <= '0;
            alu_valid_out <= FALSE;
         end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
               if (busy_q[i] && jhit[i]) begin
                  vj_q[i] <= jval[i];
                  qj_q[i] <= TAG0;
               end
               if (busy_q[i] && khit[i]) begin
                  vk_q[i] <= kval[i];
                  qk_q[i] <= TAG0;
               end
            end
            alu_valid_out <= FALSE;
            if (iss) begin
               alu_valid_out   <= TRUE;
               alu_op_out      <= op_q[rdy_idx];
               alu_vj_out      <= vj_q[rdy_idx];
               alu_vk_out      <= vk_q[rdy_idx];
               alu_imm_out     <= imm_q[rdy_idx];
               alu_rob_id_out  <= rob_q[rdy_idx];
               busy_q[rdy_idx] <= FALSE;
            end
            if (dp_acc) begin
               busy_q[free_idx] <= TRUE;
               op_q[free_idx]   <= dp_op_in;
               imm_q[free_idx]  <= dp_imm_in;
               rob_q[free_idx]  <= dp_rob_id_in;
               qj_q[free_idx]   <= dj_hit ? TAG0 : dp_qj_in;
               vj_q[free_idx]   <= dj_hit ? dj_val : dp_vj_in;
               qk_q[free_idx]   <= dk_hit ? TAG0 : dp_qk_in;
               vk_q[free_idx]   <= dk_hit ? dk_val : dp_vk_in;
            end
            if (dp_acc && !iss && count_q != MAX_CNT) begin
               count_q <= count_q + 1'b1;
            end else if (iss && !dp_acc && count_q != '0) begin
               count_q <= count_q - 1'b1;
            end
         end
      end
   end

   // A dispatch with no free entry is a dispatcher bug; it is dropped
   a_no_overflow: assert property (@(posedge clk_in) disable iff (rst_in)
      (rdy_in && !clear_in && dp_valid_in) |-> free_found);

endmodule

// File: tb/tb_param_rs.sv
// Directed-vector bench for param_rs: dispatch, CDB wake-up and bypass,
// full flag, flush, freeze and mid-run reset.
module tb_param_rs;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        clear_in;
   logic        dp_valid_in;
   logic [5:0]  dp_op_in;
   logic [3:0]  dp_qj_in;
   logic [3:0]  dp_qk_in;
   logic [31:0] dp_vj_in;
   logic [31:0] dp_vk_in;
   logic [31:0] dp_imm_in;
   logic [3:0]  dp_rob_id_in;
   logic        full_out;
   logic        alu_idle_in;
   logic        alu_valid_out;
   logic [5:0]  alu_op_out;
   logic [31:0] alu_vj_out;
   logic [31:0] alu_vk_out;
   logic [31:0] alu_imm_out;
   logic [3:0]  alu_rob_id_out;
   logic [1:0]  cdb_valid_in;
   logic [7:0]  cdb_rob_id_in;
   logic [63:0] cdb_value_in;

   int n_tests = 0;
   int n_fail  = 0;

   param_rs dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .rdy_in         (rdy_in),
      .clear_in       (clear_in),
      .dp_valid_in    (dp_valid_in),
      .dp_op_in       (dp_op_in),
      .dp_qj_in       (dp_qj_in),
      .dp_qk_in       (dp_qk_in),
      .dp_vj_in       (dp_vj_in),
      .dp_vk_in       (dp_vk_in),
      .dp_imm_in      (dp_imm_in),
      .dp_rob_id_in   (dp_rob_id_in),
      .full_out       (full_out),
      .alu_idle_in    (alu_idle_in),
      .alu_valid_out  (alu_valid_out),
      .alu_op_out     (alu_op_out),
      .alu_vj_out     (alu_vj_out),
      .alu_vk_out     (alu_vk_out),
      .alu_imm_out    (alu_imm_out),
      .alu_rob_id_out (alu_rob_id_out),
      .cdb_valid_in   (cdb_valid_in),
      .cdb_rob_id_in  (cdb_rob_id_in),
      .cdb_value_in   (cdb_value_in)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic dp(input logic [5:0] op, input logic [3:0] qj,
                     input logic [3:0] qk, input logic [31:0] vj,
                     input logic [31:0] vk, input logic [3:0] rob);
      dp_valid_in  = 1'b1;
      dp_op_in     = op;
      dp_qj_in     = qj;
      dp_qk_in     = qk;
      dp_vj_in     = vj;
      dp_vk_in     = vk;
      dp_imm_in    = {28'h0, rob};
      dp_rob_id_in = rob;
   endtask

   task automatic cdb(input int ch, input logic [3:0] tag,
                      input logic [31:0] val);
      cdb_valid_in               = 2'b00;
      cdb_valid_in[ch]           = 1'b1;
      cdb_rob_id_in[ch*4 +: 4]   = tag;
      cdb_value_in[ch*32 +: 32]  = val;
   endtask

   task automatic flush();
      clear_in = 1'b1;
      step();
      clear_in = 1'b0;
   endtask

   initial begin
      rst_in        = 1'b1;
      rdy_in        = 1'b1;
      clear_in      = 1'b0;
      dp_valid_in   = 1'b0;
      dp_op_in      = '0;
      dp_qj_in      = '0;
      dp_qk_in      = '0;
      dp_vj_in      = '0;
      dp_vk_in      = '0;
      dp_imm_in     = '0;
      dp_rob_id_in  = '0;
      alu_idle_in   = 1'b1;
      cdb_valid_in  = '0;
      cdb_rob_id_in = '0;
      cdb_value_in  = '0;
      step();
      step();
      chk("rst_valid", 32'(alu_valid_out), 32'd0);
      chk("rst_full", 32'(full_out), 32'd0);
      chk("rst_vj", alu_vj_out, 32'd0);
      chk("rst_rob", 32'(alu_rob_id_out), 32'd0);
      rst_in = 1'b0;
      step();

      // 1: ready op issues the cycle after dispatch
      dp(6'd1, 4'd0, 4'd0, 32'd5, 32'd7, 4'd3);
      step();
      dp_valid_in = 1'b0;
      chk("t1_no_early", 32'(alu_valid_out), 32'd0);
      step();
      chk("t1_valid", 32'(alu_valid_out), 32'd1);
      chk("t1_op", 32'(alu_op_out), 32'd1);
      chk("t1_vj", alu_vj_out, 32'd5);
      chk("t1_vk", alu_vk_out, 32'd7);
      chk("t1_rob", 32'(alu_rob_id_out), 32'd3);
      step();
      chk("t1_pulse", 32'(alu_valid_out), 32'd0);

      // 2: blocked on tag 2, woken by CDB ch1
      dp(6'd2, 4'd2, 4'd0, 32'd0, 32'd8, 4'd5);
      step();
      dp_valid_in = 1'b0;
      step();
      chk("t2_blocked", 32'(alu_valid_out), 32'd0);
      cdb(1, 4'd2, 32'h1234);
      step();
      cdb_valid_in = '0;
      chk("t2_wake_edge", 32'(alu_valid_out), 32'd0);
      step();
      chk("t2_valid", 32'(alu_valid_out), 32'd1);
      chk("t2_vj", alu_vj_out, 32'h1234);
      chk("t2_vk", alu_vk_out, 32'd8);
      chk("t2_rob", 32'(alu_rob_id_out), 32'd5);

      // 3: dispatch-cycle bypass on CDB ch0
      dp(6'd3, 4'd0, 4'd4, 32'd1, 32'd0, 4'd6);
      cdb(0, 4'd4, 32'd9);
      step();
      dp_valid_in  = 1'b0;
      cdb_valid_in = '0;
      step();
      chk("t3_valid", 32'(alu_valid_out), 32'd1);
      chk("t3_vk", alu_vk_out, 32'd9);
      chk("t3_rob", 32'(alu_rob_id_out), 32'd6);
      step();

      // 4: fill RS_DEPTH-1 blocked entries, then release entry 0
      for (int i = 0; i < 15; i++) begin
         dp(6'd4, (i == 0) ? 4'd9 : 4'd7, 4'd0, 32'd0, 32'd0, 4'(i));
         step();
         if (i == 13) chk("t4_full_at14", 32'(full_out), 32'd0);
      end
      dp_valid_in = 1'b0;
      chk("t4_full_at15", 32'(full_out), 32'd1);
      cdb(0, 4'd9, 32'hAA);
      step();
      cdb_valid_in = '0;
      chk("t4_full_wake", 32'(full_out), 32'd1);
      step();
      chk("t4_issue", 32'(alu_valid_out), 32'd1);
      chk("t4_issue_vj", alu_vj_out, 32'hAA);
      chk("t4_issue_rob", 32'(alu_rob_id_out), 32'd0);
      chk("t4_full_drop", 32'(full_out), 32'd0);
      flush();

      // 5: flush with a same-cycle dispatch that must be dropped
      for (int i = 0; i < 8; i++) begin
         dp(6'd5, 4'd7, 4'd0, 32'd0, 32'd0, 4'(i));
         step();
      end
      dp(6'd6, 4'd0, 4'd0, 32'd3, 32'd3, 4'd15);
      clear_in = 1'b1;
      step();
      clear_in    = 1'b0;
      dp_valid_in = 1'b0;
      chk("t5_valid", 32'(alu_valid_out), 32'd0);
      chk("t5_full", 32'(full_out), 32'd0);
      cdb(0, 4'd7, 32'd1);
      step();
      cdb_valid_in = '0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t5_no_issue", 32'(alu_valid_out), 32'd0);
      end
      alu_idle_in = 1'b0;
      for (int i = 0; i < 7; i++) begin
         dp(6'd5, 4'd7, 4'd0, 32'd0, 32'd0, 4'(i));
         step();
      end
      dp_valid_in = 1'b0;
      chk("t5_count_zero", 32'(full_out), 32'd0);
      flush();
      alu_idle_in = 1'b1;

      // 6: freeze during a pending wake, then hold an issued op
      dp(6'd7, 4'd3, 4'd0, 32'd0, 32'd2, 4'd9);
      step();
      dp_valid_in = 1'b0;
      rdy_in = 1'b0;
      cdb(0, 4'd3, 32'h55);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t6_frozen", 32'(alu_valid_out), 32'd0);
      end
      cdb_valid_in = '0;
      rdy_in = 1'b1;
      step();
      step();
      chk("t6_no_wake", 32'(alu_valid_out), 32'd0);
      cdb(0, 4'd3, 32'h55);
      step();
      cdb_valid_in = '0;
      step();
      chk("t6_valid", 32'(alu_valid_out), 32'd1);
      chk("t6_vj", alu_vj_out, 32'h55);
      rdy_in = 1'b0;
      step();
      step();
      chk("t6_hold_valid", 32'(alu_valid_out), 32'd1);
      chk("t6_hold_rob", 32'(alu_rob_id_out), 32'd9);
      rdy_in = 1'b1;
      step();
      chk("t6_resume", 32'(alu_valid_out), 32'd0);

      // mid-run reset beats a pending issue
      dp(6'd8, 4'd0, 4'd0, 32'd11, 32'd12, 4'd13);
      step();
      dp_valid_in = 1'b0;
      rst_in = 1'b1;
      step();
      chk("rst2_valid", 32'(alu_valid_out), 32'd0);
      chk("rst2_vj", alu_vj_out, 32'd0);
      chk("rst2_rob", 32'(alu_rob_id_out), 32'd0);
      chk("rst2_full", 32'(full_out), 32'd0);
      rst_in = 1'b0;
      step();
      step();
      chk("rst2_gone", 32'(alu_valid_out), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
